// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller.
package traffic_pkg;

   // Controller phases.
   typedef enum logic [1:0] {
      StAllRed = 2'd0,
      StGreen  = 2'd1,
      StYellow = 2'd2,
      StWalk   = 2'd3
   } state_e;

   // Per-direction lamp encoding, bit order {red, yellow, green}. One-hot,
   // so exactly one lamp is lit per direction.
   typedef logic [2:0] lamp_t;
   localparam lamp_t LampRed    = 3'b100;
   localparam lamp_t LampYellow = 3'b010;
   localparam lamp_t LampGreen  = 3'b001;

   // Bits needed to hold values 0..max_val (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debouncer and
// single-cycle pulse on each accepted rising edge.
module btn_debounce
   import traffic_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_i,
   output logic rise_o
);

   localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1) begin : g_chk_cycles
      $error("btn_debounce: DEBOUNCE_CYCLES must be at least 1");
   end

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            rise_q, rise_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Count consecutive cycles where the synchronised input differs from the
   // accepted level; accept the new level once the run reaches its limit.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntLast) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
      rise_d = level_d & ~level_q;
   end

   // Synchroniser, debounce state and registered rising-edge pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= button_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// N-direction round-robin traffic-light controller with all-red clearance,
// pedestrian walk phase and early green termination on a pending request.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned NUM_DIRS        = 2,
   parameter int unsigned TICK_DIV        = 100_000_000,
   parameter int unsigned GREEN_TICKS     = 20,
   parameter int unsigned MIN_GREEN_TICKS = 5,
   parameter int unsigned YELLOW_TICKS    = 3,
   parameter int unsigned ALLRED_TICKS    = 1,
   parameter int unsigned WALK_TICKS      = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        button,
   output logic [NUM_DIRS-1:0]         green,
   output logic [NUM_DIRS-1:0]         yellow,
   output logic [NUM_DIRS-1:0]         red,
   output logic                        walk,
   output logic                        ped_pending,
   output logic [$clog2(NUM_DIRS)-1:0] dir_idx
);

   localparam int unsigned DirW  = $clog2(NUM_DIRS);
   localparam int unsigned PresW = cnt_width(TICK_DIV - 1);
   localparam int unsigned MaxGY = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
   localparam int unsigned MaxAW = (ALLRED_TICKS > WALK_TICKS) ? ALLRED_TICKS : WALK_TICKS;
   localparam int unsigned MaxTicks = (MaxGY > MaxAW) ? MaxGY : MaxAW;
   localparam int unsigned ElapW = cnt_width(MaxTicks - 1);

   localparam logic [PresW-1:0] PresLast   = PresW'(TICK_DIV - 1);
   localparam logic [ElapW-1:0] GreenLast  = ElapW'(GREEN_TICKS - 1);
   localparam logic [ElapW-1:0] YellowLast = ElapW'(YELLOW_TICKS - 1);
   localparam logic [ElapW-1:0] AllRedLast = ElapW'(ALLRED_TICKS - 1);
   localparam logic [ElapW-1:0] WalkLast   = ElapW'(WALK_TICKS - 1);
   // elapsed+1 >= MIN_GREEN_TICKS rewritten to avoid a widened add.
   localparam logic [ElapW-1:0] MinGreenLast = ElapW'(MIN_GREEN_TICKS - 1);
   localparam logic [DirW-1:0]  DirLast    = DirW'(NUM_DIRS - 1);

   if (NUM_DIRS < 2 || NUM_DIRS > 8) begin : g_chk_dirs
      $error("traffic_light_ctrl: NUM_DIRS must be in 2..8");
   end
   if (TICK_DIV < 1) begin : g_chk_tick
      $error("traffic_light_ctrl: TICK_DIV must be at least 1");
   end
   if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || ALLRED_TICKS < 1 || WALK_TICKS < 1)
   begin : g_chk_dur
      $error("traffic_light_ctrl: phase durations must be at least 1");
   end
   if (MIN_GREEN_TICKS < 1 || MIN_GREEN_TICKS > GREEN_TICKS) begin : g_chk_min
      $error("traffic_light_ctrl: MIN_GREEN_TICKS must be in 1..GREEN_TICKS");
   end

   state_e             state_q, state_d;
   logic [DirW-1:0]    dir_q, dir_d;
   logic [PresW-1:0]   presc_q, presc_d;
   logic [ElapW-1:0]   elapsed_q, elapsed_d;
   logic               ped_q, ped_d;
   logic [NUM_DIRS-1:0] green_q, green_d, yellow_q, yellow_d, red_q, red_d;
   logic               walk_q, walk_d;
   logic               tick;
   logic               ped_rise;
   lamp_t              lamp;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .button_i (button),
      .rise_o   (ped_rise)
   );

   assign tick = (presc_q == PresLast);

   // Next state, tick/elapsed counters, request latch and registered lamps.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      presc_d   = tick ? '0 : presc_q + PresW'(1);
      elapsed_d = elapsed_q;
      ped_d     = ped_q;
      lamp      = LampRed;

      if (tick) begin
         elapsed_d = elapsed_q + ElapW'(1);
         unique case (state_q)
            StAllRed: begin
               if (elapsed_q == AllRedLast) state_d = ped_q ? StWalk : StGreen;
            end
            StGreen: begin
               if (elapsed_q == GreenLast || (ped_q && elapsed_q >= MinGreenLast)) begin
                  state_d = StYellow;
               end
            end
            StYellow: begin
               if (elapsed_q == YellowLast) begin
                  state_d = StAllRed;
                  dir_d   = (dir_q == DirLast) ? '0 : dir_q + DirW'(1);
               end
            end
            StWalk: begin
               if (elapsed_q == WalkLast) state_d = StAllRed;
            end
            default: state_d = StAllRed;
         endcase
      end

      // Every phase starts with fresh counters.
      if (state_d != state_q) begin
         presc_d   = '0;
         elapsed_d = '0;
      end

      // Requests arriving during WALK are dropped; clearing beats setting.
      if (ped_rise && state_q != StWalk) ped_d = 1'b1;
      if (state_d == StWalk && state_q != StWalk) ped_d = 1'b0;

      green_d  = '0;
      yellow_d = '0;
      red_d    = '0;
      for (int unsigned d = 0; d < NUM_DIRS; d++) begin
         lamp = LampRed;
         if (DirW'(d) == dir_d) begin
            if (state_d == StGreen) lamp = LampGreen;
            else if (state_d == StYellow) lamp = LampYellow;
         end
         red_d[d]    = lamp[2];
         yellow_d[d] = lamp[1];
         green_d[d]  = lamp[0];
      end
      walk_d = (state_d == StWalk);
   end

   // State, counters and outputs all update on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StAllRed;
         dir_q     <= '0;
         presc_q   <= '0;
         elapsed_q <= '0;
         ped_q     <= 1'b0;
         green_q   <= '0;
         yellow_q  <= '0;
         red_q     <= '1;
         walk_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         presc_q   <= presc_d;
         elapsed_q <= elapsed_d;
         ped_q     <= ped_d;
         green_q   <= green_d;
         yellow_q  <= yellow_d;
         red_q     <= red_d;
         walk_q    <= walk_d;
      end
   end

   assign green       = green_q;
   assign yellow      = yellow_q;
   assign red         = red_q;
   assign walk        = walk_q;
   assign ped_pending = ped_q;
   assign dir_idx     = dir_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl; cyc counts rising edges since the
// last reset release and outputs are sampled on the falling edge.
module tb_traffic_light_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       button = 1'b0;
   logic [1:0] green, yellow, red;
   logic       walk, ped_pending;
   logic [0:0] dir_idx;

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;

   traffic_light_ctrl #(
      .NUM_DIRS        (2),
      .TICK_DIV        (4),
      .GREEN_TICKS     (5),
      .MIN_GREEN_TICKS (2),
      .YELLOW_TICKS    (2),
      .ALLRED_TICKS    (1),
      .WALK_TICKS      (3),
      .DEBOUNCE_CYCLES (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .button      (button),
      .green       (green),
      .yellow      (yellow),
      .red         (red),
      .walk        (walk),
      .ped_pending (ped_pending),
      .dir_idx     (dir_idx)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_lamps(input string tag, input logic [1:0] g, input logic [1:0] y,
                              input logic [1:0] r, input logic w);
      check_eq({tag, ".green"},  32'(green),  32'(g));
      check_eq({tag, ".yellow"}, 32'(yellow), 32'(y));
      check_eq({tag, ".red"},    32'(red),    32'(r));
      check_eq({tag, ".walk"},   32'(walk),   32'(w));
   endtask

   task automatic check_ped(input string tag, input logic p);
      check_eq({tag, ".ped"}, 32'(ped_pending), 32'(p));
   endtask

   task automatic check_dir(input string tag, input logic d);
      check_eq({tag, ".dir"}, 32'(dir_idx), 32'(d));
   endtask

   // Advance to just after rising edge t (sampled on the falling edge).
   task automatic run_to(input int t);
      while (cyc < t) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      button = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      // Idle cycle: reset values, then full round-robin timing.
      do_reset();
      check_lamps("rst", 2'b00, 2'b00, 2'b11, 1'b0);
      check_ped("rst", 1'b0);
      check_dir("rst", 1'b0);
      run_to(3);  check_lamps("idle_ar_end", 2'b00, 2'b00, 2'b11, 1'b0);
      run_to(4);  check_lamps("idle_g0", 2'b01, 2'b00, 2'b10, 1'b0);
      run_to(23); check_lamps("idle_g0_end", 2'b01, 2'b00, 2'b10, 1'b0);
      run_to(24); check_lamps("idle_y0", 2'b00, 2'b01, 2'b10, 1'b0);
      run_to(31); check_lamps("idle_y0_end", 2'b00, 2'b01, 2'b10, 1'b0);
      run_to(32); check_lamps("idle_ar1", 2'b00, 2'b00, 2'b11, 1'b0);
      check_dir("idle_ar1", 1'b1);
      run_to(35); check_lamps("idle_ar1_end", 2'b00, 2'b00, 2'b11, 1'b0);
      run_to(36); check_lamps("idle_g1", 2'b10, 2'b00, 2'b01, 1'b0);
      check_dir("idle_g1", 1'b1);
      run_to(56); check_lamps("idle_y1", 2'b00, 2'b10, 2'b01, 1'b0);
      run_to(64); check_lamps("idle_wrap", 2'b00, 2'b00, 2'b11, 1'b0);
      check_dir("idle_wrap", 1'b0);

      // Short glitch (2 cycles) must not register.
      do_reset();
      button = 1'b1;
      run_to(2); button = 1'b0;
      run_to(10); check_ped("glitch", 1'b0);
      run_to(23); check_lamps("glitch_g0", 2'b01, 2'b00, 2'b10, 1'b0);

      // Bounce 1-0-1 then hold: settles high before edge 3, latched at edge 8.
      do_reset();
      button = 1'b1;
      run_to(1); button = 1'b0;
      run_to(2); button = 1'b1;
      run_to(7); check_ped("bounce_pre", 1'b0);
      run_to(8); check_ped("bounce_set", 1'b1);
      button = 1'b0;

      // Early cut: request latched in the first green tick.
      do_reset();
      button = 1'b1;
      run_to(5);  check_ped("cut_pre", 1'b0);
      run_to(6);  check_ped("cut_set", 1'b1);
      run_to(11); check_lamps("cut_g0", 2'b01, 2'b00, 2'b10, 1'b0);
      run_to(12); check_lamps("cut_y0", 2'b00, 2'b01, 2'b10, 1'b0);
      run_to(19); check_lamps("cut_y0_end", 2'b00, 2'b01, 2'b10, 1'b0);
      run_to(20); check_lamps("cut_ar", 2'b00, 2'b00, 2'b11, 1'b0);
      check_dir("cut_ar", 1'b1);
      check_ped("cut_ar", 1'b1);
      button = 1'b0;
      run_to(24); check_lamps("cut_walk", 2'b00, 2'b00, 2'b11, 1'b1);
      check_ped("cut_walk", 1'b0);
      run_to(35); check_lamps("cut_walk_end", 2'b00, 2'b00, 2'b11, 1'b1);
      run_to(36); check_lamps("cut_ar2", 2'b00, 2'b00, 2'b11, 1'b0);
      check_dir("cut_ar2", 1'b1);
      run_to(40); check_lamps("cut_g1", 2'b10, 2'b00, 2'b01, 1'b0);
      check_ped("cut_g1", 1'b0);

      // Late request in yellow, then a press during WALK that is ignored.
      do_reset();
      run_to(22); button = 1'b1;
      run_to(27); check_ped("late_pre", 1'b0);
      run_to(28); check_ped("late_set", 1'b1);
      check_lamps("late_y0", 2'b00, 2'b01, 2'b10, 1'b0);
      run_to(30); button = 1'b0;
      run_to(31); check_lamps("late_y0_end", 2'b00, 2'b01, 2'b10, 1'b0);
      run_to(32); check_lamps("late_ar", 2'b00, 2'b00, 2'b11, 1'b0);
      run_to(36); check_lamps("late_walk", 2'b00, 2'b00, 2'b11, 1'b1);
      check_ped("late_walk", 1'b0);
      check_dir("late_walk", 1'b1);
      run_to(37); button = 1'b1;
      run_to(44); check_ped("walkpress", 1'b0);
      run_to(45); button = 1'b0;
      run_to(47); check_lamps("walkpress_end", 2'b00, 2'b00, 2'b11, 1'b1);
      run_to(48); check_lamps("walkpress_ar", 2'b00, 2'b00, 2'b11, 1'b0);
      check_ped("walkpress_ar", 1'b0);
      run_to(52); check_lamps("late_g1", 2'b10, 2'b00, 2'b01, 1'b0);
      check_dir("late_g1", 1'b1);

      // Asynchronous reset in the middle of green[1].
      do_reset();
      run_to(40); check_lamps("arst_pre", 2'b10, 2'b00, 2'b01, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_lamps("arst", 2'b00, 2'b00, 2'b11, 1'b0);
      check_dir("arst", 1'b0);
      check_ped("arst", 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      run_to(3); check_lamps("arst_ar", 2'b00, 2'b00, 2'b11, 1'b0);
      run_to(4); check_lamps("arst_g0", 2'b01, 2'b00, 2'b10, 1'b0);
      check_dir("arst_g0", 1'b0);

      $display("test done: total=%0d bad=%0d", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised N-direction traffic-light controller with a debounced pedestrian-request button, all-red clearance, walk phase and early green termination. It is the next generation of the lab3 two-way light block and drives per-direction red/yellow/green lamps plus a walk lamp. Phase durations are counted in ticks from an internal prescaler. It sits between the board button input and the LED bank.

## Interface
- NUM_DIRS, 2: number of directions served round-robin; legal range 2..8.
- TICK_DIV, 100_000_000: clk cycles per tick; must be at least 1.
- GREEN_TICKS, 20: nominal green length; must be at least 1.
- MIN_GREEN_TICKS, 5: green ticks served before a pedestrian request may cut green; must satisfy 1 ≤ MIN_GREEN_TICKS ≤ GREEN_TICKS.
- YELLOW_TICKS, 3: yellow length; must be at least 1.
- ALLRED_TICKS, 1: all-red clearance length; must be at least 1.
- WALK_TICKS, 8: walk length; must be at least 1.
- DEBOUNCE_CYCLES, 1_000_000: number of consecutive stable clk cycles before the button level is accepted.
- clk  in  1  system clock, derived from sys_clkp/sys_clkn at top level.
- rst_n  in  1  asynchronous, active-low reset.
- button  in  1  raw pedestrian button; asynchronous and bouncy.
- green  out  NUM_DIRS  one bit per direction.
- yellow  out  NUM_DIRS  one bit per direction.
- red  out  NUM_DIRS  one bit per direction.
- walk  out  1  pedestrian walk lamp.
- ped_pending  out  1  pedestrian request latched and not yet served.
- dir_idx  out  $clog2(NUM_DIRS)  direction currently owning, or next to own, green.

## Operation
- States: ALLRED, GREEN, YELLOW, WALK.
- Reset values:
  - state = ALLRED, dir_idx = 0.
  - red = all ones; green, yellow, walk and ped_pending = 0.
  - Prescaler, elapsed counter and debouncer all cleared.
- Lamps in each state:
  - GREEN: green[dir_idx] = 1, every other direction red.
  - YELLOW: yellow[dir_idx] = 1, every other direction red.
  - ALLRED and WALK: all red. walk = 1 only in WALK.
  - Exactly one lamp per direction is lit at all times.
- Transitions are evaluated only on a tick. elapsed counts ticks spent in the current state.
  - ALLRED, when elapsed = ALLRED_TICKS-1: go to WALK if ped_pending, else GREEN.
  - GREEN, when elapsed = GREEN_TICKS-1: go to YELLOW.
  - GREEN early exit: if ped_pending and elapsed+1 ≥ MIN_GREEN_TICKS, go to YELLOW.
  - YELLOW, when elapsed = YELLOW_TICKS-1: go to ALLRED; dir_idx advances modulo NUM_DIRS.
  - WALK, when elapsed = WALK_TICKS-1: go to ALLRED; dir_idx unchanged.
- Pedestrian request path:
  - Button passes through a 2-flop synchroniser, then the debouncer.
  - The debounced level updates after DEBOUNCE_CYCLES consecutive cycles of a differing synchronised level.
  - A debounced rising edge sets ped_pending.
  - ped_pending clears on entry to WALK.
  - A debounced rising edge while in WALK is ignored.
  - Holding the button generates only one request.
  - If set and clear coincide, clear wins.
- Widths and wrap-around:
  - Counters are sized $clog2(max+1).
  - dir_idx wraps from NUM_DIRS-1 to 0.

## Timing
- State and all outputs are registered and update on the same clk edge. Outputs carry no extra latency.
- The prescaler and elapsed counter restart on every state entry. Each phase therefore lasts exactly duration × TICK_DIV cycles.
- Button-to-ped_pending latency is DEBOUNCE_CYCLES+3 edges after the first edge that samples button high (2 synchroniser, DEBOUNCE_CYCLES count, 1 edge detect).
- Reset mid-operation forces reset values immediately; no clk is needed. The first transition occurs ALLRED_TICKS × TICK_DIV cycles after rst_n rises.

## Structure
- Package traffic_pkg holds:
  - the state enum;
  - the lamp-encoding constants;
  - a width helper function.
- Sub-module btn_debounce contains the synchroniser, the stable counter and the rising-edge pulse output. It is parametrised by DEBOUNCE_CYCLES.
- Parameter legality is checked at elaboration with $error.

## Test plan
All scenarios use NUM_DIRS=2, TICK_DIV=4, GREEN_TICKS=5, MIN_GREEN_TICKS=2, YELLOW_TICKS=2, ALLRED_TICKS=1, WALK_TICKS=3, DEBOUNCE_CYCLES=3.
- **Idle cycle:** release reset, no button.
  - ALLRED for 4 cycles, then green[0] for 20 cycles, yellow[0] for 8, all-red for 4.
  - green[1] asserts at cycle 36; dir_idx wraps to 0 after direction 1's yellow.
- **Debounce:** button bounces 1-0-1 on single cycles, then is held high.
  - ped_pending rises exactly 6 edges after the last bounce settles high.
  - Glitches shorter than 3 cycles produce no request.
- **Early cut:** request latched during the 1st tick of green[0].
  - Yellow starts at the end of tick 2 (8 cycles into green), then ALLRED.
  - WALK for 12 cycles with ped_pending cleared on entry.
  - ALLRED, then green[1].
- **Late request:** request latched in YELLOW.
  - No truncation; WALK follows the next ALLRED.
  - Green then resumes with the advanced dir_idx.
- **Request in WALK:** press while walk=1.
  - ped_pending stays 0 and no second WALK occurs.
- **Async reset:** assert rst_n low mid-GREEN between clk edges.
  - All outputs take reset values in the same timestep.
  - The sequence restarts from ALLRED with dir_idx = 0.
